// File: rtl/regfile_mp_pkg.sv
// Shared state encoding, default sizes and helpers for the multi-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: writes clear, reservations set (set wins),
// looked up combinationally on every read port.
module rf_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr0,
    input  logic [AW-1:0]     clr0_addr,
    input  logic              clr1,
    input  logic [AW-1:0]     clr1_addr,
    input  logic              set,
    input  logic [AW-1:0]     set_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // A new producer issued in the same cycle as the old one retires keeps the bit set
    always_comb begin
        busy_nxt = busy_q;
        if (clr0) busy_nxt[clr0_addr] = 1'b0;
        if (clr1) busy_nxt[clr1_addr] = 1'b0;
        if (set)  busy_nxt[set_addr]  = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NRD; i++) begin
            busy[i] = busy_q[ra[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, optional bypass,
// hardwired zero register, busy scoreboard and post-reset clearing sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 ready
);

    state_e           state;
    state_e           state_nxt;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             run;
    logic             wen0;
    logic             wen1;
    logic             rsv;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
    end

    // Writes and reservations only take effect once the sweep has finished
    always_comb begin
        run  = (state == ST_RUN);
        wen0 = run && we0 && !(ZERO_REG && wa0 == '0);
        wen1 = run && we1 && !(ZERO_REG && wa1 == '0);
        rsv  = run && rsv_en;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            if (state == ST_INIT) cnt <= cnt + AW'(1);
            ready <= (state_nxt == ST_RUN);
        end
    end

    // Port 1 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            if (!run) begin
                mem[cnt] <= '0;
            end else begin
                if (wen0) mem[wa0] <= wd0;
                if (wen1) mem[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!run || (ZERO_REG && ra[i*AW +: AW] == '0))
                rd[i*WIDTH +: WIDTH] = '0;
            else if (BYPASS && wen1 && wa1 == ra[i*AW +: AW])
                rd[i*WIDTH +: WIDTH] = wd1;
            else if (BYPASS && wen0 && wa0 == ra[i*AW +: AW])
                rd[i*WIDTH +: WIDTH] = wd0;
            else
                rd[i*WIDTH +: WIDTH] = mem[ra[i*AW +: AW]];
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .clr0      (run && we0),
        .clr0_addr (wa0),
        .clr1      (run && we1),
        .clr1_addr (wa1),
        .set       (rsv),
        .set_addr  (rsv_addr),
        .ra        (ra),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 2-port and a non-bypassing 4-port instance
// share one stimulus stream and are compared every cycle against an array model.
module tb_regfile_mp;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [4*AW-1:0] ra;
    logic            we0, we1, rsv_en;
    logic [AW-1:0]   wa0, wa1, rsv_addr;
    logic [W-1:0]    wd0, wd1;
    logic [2*W-1:0]  rd_a;
    logic [1:0]      busy_a;
    logic            ready_a;
    logic [4*W-1:0]  rd_b;
    logic [3:0]      busy_b;
    logic            ready_b;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .reset(reset), .ra(ra[2*AW-1:0]), .rd(rd_a), .busy(busy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready_a)
    );

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .busy(busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready_b)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays plus a sweep countdown
    logic [W-1:0] m_mem  [D];
    bit           m_busy [D];
    bit           m_init  = 1'b0;
    bit           m_ready = 1'b0;
    int           m_cnt   = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_init  = 1'b1;
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
        end else if (m_init) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) begin
                m_init  = 1'b0;
                m_ready = 1'b1;
            end
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0) m_busy[wa0] = 1'b0;
            if (we1) m_busy[wa1] = 1'b0;
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (m_init || a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        return m_init ? 1'b0 : m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("a.rd%0d", i), rd_a[i*W +: W], exp_rd(ra[i*AW +: AW], 1'b1));
                chk($sformatf("a.busy%0d", i), W'(busy_a[i]), W'(exp_busy(ra[i*AW +: AW])));
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("b.rd%0d", i), rd_b[i*W +: W], exp_rd(ra[i*AW +: AW], 1'b0));
                chk($sformatf("b.busy%0d", i), W'(busy_b[i]), W'(exp_busy(ra[i*AW +: AW])));
            end
            chk("a.ready", W'(ready_a), W'(m_ready));
            chk("b.ready", W'(ready_b), W'(m_ready));
        end
    end

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_ra(input int p, input int a);
        ra[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [W-1:0] rda(input int p);
        return rd_a[p*W +: W];
    endfunction

    function automatic logic [W-1:0] rdb(input int p);
        return rd_b[p*W +: W];
    endfunction

    // Called just after reset is released; counts cycles with ready low
    task automatic count_init(input string name);
        int n;
        n = 0;
        while (n < 100) begin
            if (ready_a) break;
            n++;
            tick();
        end
        chk(name, W'(n), W'(D));
    endtask

    initial begin
        reset = 1'b0; ra = '0; idle();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b1;
        count_init("first_sweep");

        // Preload entry 5, then reset with we0 held high through the sweep
        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEAD_BEEF; tick(); idle();
        set_ra(0, 5);
        @(negedge clk); chk("preload5", rda(0), 32'hDEAD_BEEF); tick();
        reset = 1'b0; we0 = 1'b1; tick(); tick();
        reset = 1'b1;
        count_init("ready_low_cycles");
        idle();
        @(negedge clk); chk("sweep_cleared5", rda(0), 32'h0); tick();

        // Basic write/read and zero register
        we0 = 1'b1; wa0 = 3; wd0 = 32'h1234_5678; set_ra(0, 3); set_ra(1, 3);
        @(negedge clk); chk("bypass_w3", rda(0), 32'h1234_5678); tick(); idle();
        @(negedge clk);
        chk("read3_p0", rda(0), 32'h1234_5678);
        chk("read3_p1", rda(1), 32'h1234_5678);
        chk("read3_nobyp", rdb(0), 32'h1234_5678);
        tick();
        we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF_FFFF; set_ra(0, 0);
        @(negedge clk); chk("zero_bypass", rda(0), 32'h0); tick(); idle();
        @(negedge clk); chk("zero_read", rda(0), 32'h0); tick();

        // Dual-write collision
        we0 = 1'b1; wa0 = 7; wd0 = 32'hA; we1 = 1'b1; wa1 = 7; wd1 = 32'hB; set_ra(0, 7);
        @(negedge clk);
        chk("coll_bypass", rda(0), 32'hB);
        chk("coll_nobyp_old", rdb(0), 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("coll_stored", rda(0), 32'hB);
        chk("coll_nobyp_new", rdb(0), 32'hB);
        tick();

        // Scoreboard
        set_ra(0, 9); rsv_en = 1'b1; rsv_addr = 9;
        @(negedge clk); chk("busy_not_bypassed", W'(busy_a[0]), W'(0)); tick(); idle();
        @(negedge clk); chk("busy_set", W'(busy_a[0]), W'(1)); tick();
        we1 = 1'b1; wa1 = 9; wd1 = 32'h5; tick(); idle();
        @(negedge clk); chk("busy_cleared", W'(busy_a[0]), W'(0)); tick();
        we1 = 1'b1; wa1 = 9; rsv_en = 1'b1; rsv_addr = 9; tick(); idle();
        @(negedge clk); chk("busy_set_wins", W'(busy_a[0]), W'(1)); tick();
        set_ra(0, 0); rsv_en = 1'b1; rsv_addr = 0; tick(); idle();
        @(negedge clk); chk("busy_zero", W'(busy_a[0]), W'(0)); tick();

        // Reset mid-run
        for (int i = 1; i <= 4; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = W'(32'h1111_1111 * i); tick();
        end
        idle(); rsv_en = 1'b1; rsv_addr = 6; tick(); idle();
        set_ra(0, 6);
        @(negedge clk); chk("busy6_before", W'(busy_a[0]), W'(1)); tick();
        reset = 1'b0; tick();
        reset = 1'b1;
        chk("busy6_after_reset", W'(busy_a[0]), W'(0));
        chk("ready_after_reset", W'(ready_a), W'(0));
        count_init("midrun_sweep");
        for (int p = 0; p < 4; p++) set_ra(p, p + 1);
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk($sformatf("cleared%0d", p + 1), rdb(p), 32'h0);
        tick();

        // Four distinct addresses read at once
        we0 = 1'b1; wa0 = 10; wd0 = 32'hC0DE_0010; we1 = 1'b1; wa1 = 11; wd1 = 32'hC0DE_0011; tick();
        we0 = 1'b1; wa0 = 12; wd0 = 32'hC0DE_0012; we1 = 1'b1; wa1 = 13; wd1 = 32'hC0DE_0013; tick();
        idle();
        for (int p = 0; p < 4; p++) set_ra(p, 10 + p);
        @(negedge clk);
        chk("quad0", rdb(0), 32'hC0DE_0010);
        chk("quad1", rdb(1), 32'hC0DE_0011);
        chk("quad2", rdb(2), 32'hC0DE_0012);
        chk("quad3", rdb(3), 32'hC0DE_0013);
        tick();

        // Randomised traffic over a narrow address range to force collisions
        repeat (800) begin
            reset    = ($urandom_range(0, 299) != 0);
            we0      = 1'($urandom_range(0, 1));
            we1      = 1'($urandom_range(0, 1));
            rsv_en   = 1'($urandom_range(0, 2) == 0);
            wa0      = AW'($urandom_range(0, 11));
            wa1      = AW'($urandom_range(0, 11));
            rsv_addr = AW'($urandom_range(0, 11));
            wd0      = W'($urandom);
            wd1      = W'($urandom);
            for (int p = 0; p < 4; p++) set_ra(p, int'($urandom_range(0, 11)));
            tick();
        end
        reset = 1'b1; idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
